// File: rtl/msfsm_gate_mealy.sv
// msfsm_gate_mealy: N-input AND/OR gate built from communicating Mealy FSMs.
// Each input has a LOW/HIGH level tracker driven by +/- event strobes.
// A single output FSM emits rise/fall strobes in the same cycle as the input
// event that completes them. Bad events (a rise while HIGH, a fall while LOW,
// or both at once) are dropped. They set a sticky error flag and record the
// lowest offending index.
//
// Optional build macro MSFSM_OUT_REG_EN: when defined, out_P/out_M come from
// a register. They appear one cycle after the completing event.
module msfsm_gate_mealy #(
  parameter int N_IN       = 2,
  parameter bit GATE_OR    = 1'b0,
  parameter bit INIT_LEVEL = 1'b0,
  localparam int IDX_W     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  in_P,
  input  logic [N_IN-1:0]  in_M,
  output logic             out_P,
  output logic             out_M,
  output logic [N_IN-1:0]  lvl,
  output logic             out_lvl,
  output logic             err,
  output logic [IDX_W-1:0] err_idx
);

  typedef enum logic {LOW  = 1'b0, HIGH = 1'b1} in_state_e;
  typedef enum logic {OUT_LOW = 1'b0, OUT_HIGH = 1'b1} out_state_e;

  in_state_e  lvl_q [N_IN];
  in_state_e  lvl_d [N_IN];
  out_state_e out_q, out_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;

  logic [N_IN-1:0]  cur_hi;    // current per-input level, packed
  logic [N_IN-1:0]  nxt;       // per-input level after valid events
  logic [N_IN-1:0]  err_bits;  // per-input protocol violation this cycle
  logic [IDX_W-1:0] first_idx; // lowest violating index this cycle
  logic             f;         // gate function of the next levels
  logic             rise, fall;

  // Per-input FSMs plus error detection: compute next levels from valid events only.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    cur_hi    = '0;
    nxt       = '0;
    err_bits  = '0;
    first_idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      lvl_d[i]  = lvl_q[i];
      cur_hi[i] = (lvl_q[i] == HIGH);
    end
    for (int i = 0; i < N_IN; i++) begin
      err_bits[i] = (in_P[i] & in_M[i]) | (in_P[i] & cur_hi[i]) | (in_M[i] & ~cur_hi[i]);
      if (in_P[i] && !in_M[i] && !cur_hi[i]) begin
        lvl_d[i] = HIGH;
      end else if (in_M[i] && !in_P[i] && cur_hi[i]) begin
        lvl_d[i] = LOW;
      end
      nxt[i] = (lvl_d[i] == HIGH);
    end
    // Scan from the top down so the lowest offending index is the one that remains.
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (err_bits[i]) first_idx = IDX_W'(i);
    end
  end

  // Output FSM and error bookkeeping: gate function, Mealy strobes, sticky error.
  always_comb begin
    f     = GATE_OR ? (|nxt) : (&nxt);
    out_d = f ? OUT_HIGH : OUT_LOW;
    rise  = (out_q == OUT_LOW)  &  f;
    fall  = (out_q == OUT_HIGH) & ~f;
    err_d     = err_q | (|err_bits);
    err_idx_d = err_idx_q;
    if (!err_q && (|err_bits)) err_idx_d = first_idx;
  end

  // State registers for all FSMs, with synchronous active-low reset to INIT_LEVEL.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) lvl_q[i] <= INIT_LEVEL ? HIGH : LOW;
      out_q     <= INIT_LEVEL ? OUT_HIGH : OUT_LOW;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) lvl_q[i] <= lvl_d[i];
      out_q     <= out_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

`ifdef MSFSM_OUT_REG_EN
  logic out_p_q, out_m_q;

  // Registered strobes: delay the rise/fall pulses by one cycle and clear them on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_p_q <= 1'b0;
      out_m_q <= 1'b0;
    end else begin
      out_p_q <= rise;
      out_m_q <= fall;
    end
  end

  // Reset also masks the registered strobe, so a pulse pending across a reset cycle is dropped.
  assign out_P = reset & out_p_q;
  assign out_M = reset & out_m_q;
`else
  // Pure Mealy strobes, suppressed while reset is held low.
  assign out_P = reset & rise;
  assign out_M = reset & fall;
`endif

  // Flatten the per-input state for the level output.
  always_comb begin
    lvl = '0;
    for (int i = 0; i < N_IN; i++) lvl[i] = (lvl_q[i] == HIGH);
  end

  assign out_lvl = (out_q == OUT_HIGH);
  assign err     = err_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_msfsm_gate_mealy.sv
// Bench for msfsm_gate_mealy with three instances: AND/2, AND/4 and OR/3.
// Vectors carry hand-derived expectations. Expected strobes go into a queue
// when a vector is driven. They are popped and compared once the DUT should
// show them, which is the same cycle for Mealy and one cycle later for the
// registered build.
module tb_msfsm_gate_mealy;

`ifdef MSFSM_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [1:0] p0, m0;
  logic [3:0] p1, m1;
  logic [2:0] p2, m2;
  logic       op0, om0, op1, om1, op2, om2;
  logic [1:0] l0;
  logic [3:0] l1;
  logic [2:0] l2;
  logic       ol0, ol1, ol2, e0, e1, e2;
  logic       ei0;
  logic [1:0] ei1, ei2;

  msfsm_gate_mealy #(.N_IN(2), .GATE_OR(1'b0), .INIT_LEVEL(1'b0)) u_and2 (
    .clk(clk), .reset(rst_n), .in_P(p0), .in_M(m0), .out_P(op0), .out_M(om0),
    .lvl(l0), .out_lvl(ol0), .err(e0), .err_idx(ei0));

  msfsm_gate_mealy #(.N_IN(4), .GATE_OR(1'b0), .INIT_LEVEL(1'b0)) u_and4 (
    .clk(clk), .reset(rst_n), .in_P(p1), .in_M(m1), .out_P(op1), .out_M(om1),
    .lvl(l1), .out_lvl(ol1), .err(e1), .err_idx(ei1));

  msfsm_gate_mealy #(.N_IN(3), .GATE_OR(1'b1), .INIT_LEVEL(1'b0)) u_or3 (
    .clk(clk), .reset(rst_n), .in_P(p2), .in_M(m2), .out_P(op2), .out_M(om2),
    .lvl(l2), .out_lvl(ol2), .err(e2), .err_idx(ei2));

  typedef struct {
    int         dut;
    logic       rst_n;
    logic [3:0] p, m;
    logic       ep, em;
    logic [3:0] elvl;
    logic       eout, eerr;
    logic [1:0] eidx;
  } vec_t;

  typedef struct {
    int   dut;
    logic p, m;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input int dut, input logic r, input logic [3:0] p, input logic [3:0] m,
                              input logic ep, input logic em, input logic [3:0] elvl,
                              input logic eout, input logic eerr, input logic [1:0] eidx);
    vec_t v;
    v.dut = dut; v.rst_n = r; v.p = p; v.m = m; v.ep = ep; v.em = em;
    v.elvl = elvl; v.eout = eout; v.eerr = eerr; v.eidx = eidx;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic get_strb(input int dut, output logic sp, output logic sm);
    case (dut)
      0:       begin sp = op0; sm = om0; end
      1:       begin sp = op1; sm = om1; end
      default: begin sp = op2; sm = om2; end
    endcase
  endtask

  task automatic get_state(input int dut, output logic [3:0] lv, output logic o,
                           output logic e, output logic [1:0] idx);
    case (dut)
      0:       begin lv = {2'b00, l0}; o = ol0; e = e0; idx = {1'b0, ei0}; end
      1:       begin lv = l1;          o = ol1; e = e1; idx = ei1;         end
      default: begin lv = {1'b0, l2};  o = ol2; e = e2; idx = ei2;         end
    endcase
  endtask

  // Drive one cycle of stimulus, compare strobes at the negedge and state after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t       e, f;
    logic       sp, sm, o, er;
    logic [3:0] lv;
    logic [1:0] idx;
    rst_n = v.rst_n;
    p0 = (v.dut == 0) ? v.p[1:0] : '0;  m0 = (v.dut == 0) ? v.m[1:0] : '0;
    p1 = (v.dut == 1) ? v.p      : '0;  m1 = (v.dut == 1) ? v.m      : '0;
    p2 = (v.dut == 2) ? v.p[2:0] : '0;  m2 = (v.dut == 2) ? v.m[2:0] : '0;
    e.dut = v.dut; e.p = v.ep; e.m = v.em;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() > LAT) begin
      f = sb.pop_front();
      if (!rst_n) begin f.p = 1'b0; f.m = 1'b0; end
      get_strb(f.dut, sp, sm);
      check({tag, " out_P"}, {31'd0, sp}, {31'd0, f.p});
      check({tag, " out_M"}, {31'd0, sm}, {31'd0, f.m});
    end
    @(posedge clk);
    #1;
    get_state(v.dut, lv, o, er, idx);
    check({tag, " lvl"},     {28'd0, lv},  {28'd0, v.elvl});
    check({tag, " out_lvl"}, {31'd0, o},   {31'd0, v.eout});
    check({tag, " err"},     {31'd0, er},  {31'd0, v.eerr});
    check({tag, " err_idx"}, {30'd0, idx}, {30'd0, v.eidx});
  endtask

  initial begin
    rst_n = 1'b0;
    p0 = '0; m0 = '0; p1 = '0; m1 = '0; p2 = '0; m2 = '0;

    //                dut rst  in_P     in_M     eP eM  lvl      out  err  idx
    vecs.push_back(mk(0, 1'b0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0,   0,   2'd0)); // reset
    vecs.push_back(mk(0, 1'b0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0,   0,   2'd0));
    vecs.push_back(mk(0, 1'b1, 4'b0001, 4'b0000, 0, 0, 4'b0001, 0,   0,   2'd0)); // AND2 first rise
    vecs.push_back(mk(0, 1'b1, 4'b0010, 4'b0000, 1, 0, 4'b0011, 1,   0,   2'd0)); // completes AND
    vecs.push_back(mk(0, 1'b1, 4'b0000, 4'b0001, 0, 1, 4'b0010, 0,   0,   2'd0)); // fall
    vecs.push_back(mk(1, 1'b1, 4'b1111, 4'b0000, 1, 0, 4'b1111, 1,   0,   2'd0)); // AND4 all at once
    vecs.push_back(mk(1, 1'b1, 4'b0000, 4'b0011, 0, 1, 4'b1100, 0,   0,   2'd0)); // two fall, one strobe
    vecs.push_back(mk(2, 1'b1, 4'b0001, 4'b0000, 1, 0, 4'b0001, 1,   0,   2'd0)); // OR3 rises
    vecs.push_back(mk(2, 1'b1, 4'b0010, 4'b0000, 0, 0, 4'b0011, 1,   0,   2'd0));
    vecs.push_back(mk(2, 1'b1, 4'b0000, 4'b0001, 0, 0, 4'b0010, 1,   0,   2'd0));
    vecs.push_back(mk(2, 1'b1, 4'b0000, 4'b0010, 0, 1, 4'b0000, 0,   0,   2'd0)); // last high falls
    vecs.push_back(mk(1, 1'b1, 4'b0001, 4'b0100, 0, 0, 4'b1001, 0,   0,   2'd0)); // concurrent, f stays 0
    vecs.push_back(mk(1, 1'b1, 4'b0100, 4'b0001, 0, 0, 4'b1100, 0,   0,   2'd0));
    vecs.push_back(mk(1, 1'b1, 4'b0100, 4'b0000, 0, 0, 4'b1100, 0,   1,   2'd2)); // rise while HIGH
    vecs.push_back(mk(1, 1'b1, 4'b0011, 4'b0001, 0, 0, 4'b1110, 0,   1,   2'd2)); // P&M on bit0, bit1 valid
    vecs.push_back(mk(1, 1'b1, 4'b0001, 4'b0000, 1, 0, 4'b1111, 1,   1,   2'd2)); // still works after error

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-operation: a pending fall is discarded and no strobe is issued.
    apply(mk(0, 1'b1, 4'b0001, 4'b0000, 1, 0, 4'b0011, 1, 0, 2'd0), "rst_setup");
    apply(mk(0, 1'b0, 4'b0000, 4'b0001, 0, 0, 4'b0000, 0, 0, 2'd0), "rst_cycle");
    apply(mk(0, 1'b1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0), "rst_after");

    // First error on several bits records the lowest index, and later errors leave it alone.
    apply(mk(1, 1'b1, 4'b0000, 4'b1010, 0, 0, 4'b0000, 0, 1, 2'd1), "err_multi");
    apply(mk(1, 1'b1, 4'b0000, 4'b0001, 0, 0, 4'b0000, 0, 1, 2'd1), "err_later");
    apply(mk(1, 1'b1, 4'b1111, 4'b0000, 1, 0, 4'b1111, 1, 1, 2'd1), "err_then_valid");
    apply(mk(1, 1'b1, 4'b0000, 4'b0000, 0, 0, 4'b1111, 1, 1, 2'd1), "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

endmodule
